// File: rtl/mc_defs.sv
// Shared encodings for the multicycle MIPS controller: FSM states, opcodes and
// datapath select codes, plus small decode helpers.
package mc_defs;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RTWB   = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Final state of every legal instruction; leaving it retires the instruction.
  function automatic logic is_retire(input state_t s);
    return (s == S_MEMWB) || (s == S_MEMWR) || (s == S_RTWB) ||
           (s == S_BRANCH) || (s == S_JUMP) || (s == S_ADDIWB);
  endfunction

  function automatic logic is_legal(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/mc_retire_counter.sv
// Retired-instruction counter: wraps modulo 2^CNT_W, cleared by async reset.
module mc_retire_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Moore controller for the multicycle MIPS datapath: sequences fetch/decode/
// execute/memory/write-back, counts retired instructions, flags bad opcodes.
module mc_control_fsm
  import mc_defs::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step_en,
  input  logic [5:0]       opcode,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemtoReg,
  output logic             IRWrite,
  output logic             ALUSrcA,
  output logic             RegWrite,
  output logic             RegDst,
  output logic [1:0]       PCSource,
  output logic [1:0]       ALUOp,
  output logic [1:0]       ALUSrcB,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_count
);

  state_t state_q;
  state_t state_d;
  logic   strobe_en;
  logic   pc_write_raw, pc_write_cond_raw, mem_read_raw;
  logic   mem_write_raw, ir_write_raw, reg_write_raw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_FETCH;
      illegal_op <= 1'b0;
    end else begin
      if (step_en) begin
        state_q <= state_d;
      end
      // Single-cycle pulse; any edge without a fresh bad decode clears it.
      illegal_op <= step_en && (state_q == S_DECODE) && !is_legal(opcode);
    end
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDIEX;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = S_MEMWB;
      S_EXEC:   state_d = S_RTWB;
      S_ADDIEX: state_d = S_ADDIWB;
      default:  state_d = S_FETCH;
    endcase
  end

  always_comb begin
    pc_write_raw      = 1'b0;
    pc_write_cond_raw = 1'b0;
    mem_read_raw      = 1'b0;
    mem_write_raw     = 1'b0;
    ir_write_raw      = 1'b0;
    reg_write_raw     = 1'b0;
    IorD              = 1'b0;
    MemtoReg          = 1'b0;
    ALUSrcA           = 1'b0;
    RegDst            = 1'b0;
    PCSource          = PCSRC_ALU;
    ALUOp             = ALUOP_ADD;
    ALUSrcB           = SRCB_B;
    case (state_q)
      S_FETCH: begin
        mem_read_raw = 1'b1;
        ir_write_raw = 1'b1;
        pc_write_raw = 1'b1;
        ALUSrcB      = SRCB_FOUR;
      end
      S_DECODE: ALUSrcB = SRCB_IMM_SH2;
      S_MEMADR, S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMRD: begin
        mem_read_raw = 1'b1;
        IorD         = 1'b1;
      end
      S_MEMWB: begin
        MemtoReg      = 1'b1;
        reg_write_raw = 1'b1;
      end
      S_MEMWR: begin
        mem_write_raw = 1'b1;
        IorD          = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALUOP_FUNCT;
      end
      S_RTWB: begin
        RegDst        = 1'b1;
        reg_write_raw = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA           = 1'b1;
        ALUOp             = ALUOP_SUB;
        PCSource          = PCSRC_ALUOUT;
        pc_write_cond_raw = 1'b1;
      end
      S_JUMP: begin
        PCSource     = PCSRC_JUMP;
        pc_write_raw = 1'b1;
      end
      S_ADDIWB: reg_write_raw = 1'b1;
      default: ;
    endcase
  end

  // Reset is folded in so strobes drop immediately on async assertion.
  assign strobe_en   = step_en && rst_n;
  assign PCWrite     = pc_write_raw && strobe_en;
  assign PCWriteCond = pc_write_cond_raw && strobe_en;
  assign MemRead     = mem_read_raw && strobe_en;
  assign MemWrite    = mem_write_raw && strobe_en;
  assign IRWrite     = ir_write_raw && strobe_en;
  assign RegWrite    = reg_write_raw && strobe_en;

  mc_retire_counter #(
    .CNT_W (CNT_W)
  ) u_retire_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (step_en && is_retire(state_q)),
    .count (instr_count)
  );

endmodule
